// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller driving one external full adder.
// Processes operands LSB first, one bit per clock, WIDTH cycles per add.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx;

  // Full-adder drive is gated by the registered busy flag.
  assign fa_x   = busy & a_reg[idx];
  assign fa_y   = busy & b_reg[idx];
  assign fa_cin = busy & carry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
            state     <= S_RUN;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else begin
            sum[idx]  <= fa_sum;
            carry_reg <= fa_cout;
            if (idx == LAST) begin
              cout  <= fa_cout;
              idx   <= '0;
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed cases plus random additions
// checked against plain integer arithmetic.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic         fa_x, fa_y, fa_cin;
  logic         fa_sum, fa_cout;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign fa_sum  = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int carry_into(input int a, input int b,
                                    input int c, input int k);
    int m;
    m = (1 << k) - 1;
    return (((a & m) + (b & m) + c) >> k) & 1;
  endfunction

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit hold);
    int nb;
    bit bad;
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    op_a = 8'h55; op_b = 8'hAA; op_cin = ~cin;
    nb = 0; bad = 0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (busy && !done) nb++;
      if (fa_x !== a[k] || fa_y !== b[k] ||
          fa_cin !== 1'(carry_into(int'(a), int'(b), int'(cin), k)))
        bad = 1;
    end
    check("busy_cycles", 64'(nb), 64'(W));
    check("fa_drive", 64'(bad), 64'd0);
    @(negedge clk);
    check("done", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    check("result", 64'({cout, sum}), 64'(a) + 64'(b) + 64'(cin));
    check("fa_idle", 64'({fa_x, fa_y, fa_cin}), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rc;
    #2;
    check("rst_outs", 64'({busy, done, cout, sum, fa_x, fa_y, fa_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_add(8'h0F, 8'h01, 1'b0, 0);
    do_add(8'hFF, 8'h01, 1'b0, 0);
    do_add(8'hFF, 8'hFF, 1'b1, 0);
    do_add(8'h3C, 8'h5A, 1'b0, 1);

    // results hold through idle
    repeat (2) @(negedge clk);
    check("hold_sum", 64'({cout, sum}), 64'h096);

    // abort in the 4th run cycle
    @(negedge clk);
    op_a = 8'hF0; op_b = 8'h0F; op_cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    abort = 1'b0;
    @(negedge clk);
    check("abort_nodone", 64'(done), 64'd0);
    do_add(8'h03, 8'h04, 1'b0, 0);

    // asynchronous reset mid-run
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; op_cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async",
          64'({busy, done, cout, sum, fa_x, fa_y, fa_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_add(8'h80, 8'h80, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      do_add(ra, rb, rc, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request a new addition.
REQ-005 SHALL have port abort, input, 1, synchronous cancel of the operation in progress.
REQ-006 SHALL have port op_a, input, WIDTH, first operand.
REQ-007 SHALL have port op_b, input, WIDTH, second operand.
REQ-008 SHALL have port op_cin, input, 1, carry-in for bit 0.
REQ-009 SHALL have port fa_x, output, 1, x drive to the external 1-bit full adder.
REQ-010 SHALL have port fa_y, output, 1, y drive to the full adder.
REQ-011 SHALL have port fa_cin, output, 1, cin drive to the full adder.
REQ-012 SHALL have port fa_sum, input, 1, sum (A) returned by the full adder, combinational from fa_x/fa_y/fa_cin.
REQ-013 SHALL have port fa_cout, input, 1, carry returned by the full adder.
REQ-014 SHALL have port busy, output, 1, high while in RUN.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port sum, output, WIDTH, registered result.
REQ-017 SHALL have port cout, output, 1, registered final carry.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE, encoded in a state register.
REQ-019 In IDLE, start=1 at a clock edge SHALL latch op_a, op_b into operand registers, latch op_cin into the carry register, clear bit index to 0, and go to RUN.
REQ-020 start SHALL be ignored in RUN and DONE; operands are not re-latched.
REQ-021 In RUN, fa_x, fa_y and fa_cin SHALL equal a_reg[idx], b_reg[idx] and carry_reg combinationally from registers, and SHALL be 0 in IDLE and DONE.
REQ-022 Each RUN edge SHALL write fa_sum into sum_reg[idx] and fa_cout into carry_reg, then increment idx; LSB is processed first.
REQ-023 RUN SHALL last exactly WIDTH cycles; the edge with idx==WIDTH-1 SHALL transfer to DONE and load cout from fa_cout.
REQ-024 DONE SHALL last one cycle with done=1, then return unconditionally to IDLE.
REQ-025 Latency: start sampled at edge 0 gives done high in the cycle after edge WIDTH+... i.e. done asserted between edges WIDTH and WIDTH+1.
REQ-026 sum and cout SHALL hold their last completed values through IDLE and SHALL update bit-by-bit only during RUN.
REQ-027 sum and cout are valid only while done=1 or in the following IDLE.
REQ-028 abort=1 in RUN SHALL return to IDLE on the next edge with no done pulse, and sum/cout contents undefined-but-stable (partial); abort has priority over the idx==WIDTH-1 transfer.
REQ-029 abort SHALL be ignored in IDLE and DONE; start and abort both high in IDLE SHALL start an operation.
REQ-030 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both are derived from registers, glitch-free.
REQ-031 The idx counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, idx=0, carry_reg=0, operand registers=0, sum=0, cout=0, busy=0, done=0, and fa_x=fa_y=fa_cin=0.
REQ-033 Reset asserted mid-RUN SHALL discard the operation; the first start after rst_n rises SHALL behave as from power-up.

Verification (WIDTH=8, full adder model attached)
REQ-034 op_a=0x0F, op_b=0x01, op_cin=0, pulse start -> busy for 8 cycles, done in the 9th cycle, sum=0x10, cout=0.
REQ-035 op_a=0xFF, op_b=0x01, op_cin=0 -> sum=0x00, cout=1; op_a=0xFF, op_b=0xFF, op_cin=1 -> sum=0xFF, cout=1.
REQ-036 start held high throughout RUN with operands changed to 0x55/0xAA after the first edge -> result uses the first latched operands only; exactly one done pulse per accepted start.
REQ-037 abort at RUN cycle 4 -> IDLE next edge, no done pulse, busy=0; a following start with 0x03+0x04 yields sum=0x07, cout=0.
REQ-038 rst_n low at RUN cycle 3, asynchronously between edges -> all outputs 0 immediately; after release, 0x80+0x80 cin=0 yields sum=0x00, cout=1.
REQ-039 Random regression: 1000 random operand/cin triples; {cout,sum} SHALL equal op_a+op_b+op_cin, and fa_x/fa_y/fa_cin SHALL be 0 outside RUN.
